// File: rtl/rx_symbol_packer.sv
// rx_symbol_packer: packs 8b/10b-decoded symbols into 8/16/32-bit MAC words with error status.
// Optional comma realignment is enabled by defining RX_PACKER_COM_ALIGN_EN.
module rx_symbol_packer #(
  parameter int SYM_WIDTH = 8
) (
  input  logic                 Word_CLK,
  input  logic                 Reset,
  input  logic [SYM_WIDTH-1:0] Sym_Data,
  input  logic                 Sym_K,
  input  logic                 Sym_Valid,
  input  logic                 Sym_DecErr,
  input  logic                 Sym_DispErr,
  input  logic                 Sym_Lock,
  input  logic [5:0]           DataBusWidth,
  output logic [31:0]          Rx_Data,
  output logic [3:0]           Rx_DataK,
  output logic [2:0]           Rx_Status,
  output logic                 Rx_Valid,
  output logic                 Align_Event
);

  localparam logic [2:0] ST_OK   = 3'b000;
  localparam logic [2:0] ST_DEC  = 3'b100;
  localparam logic [2:0] ST_DISP = 3'b111;

  logic [2:0]  lanes_q, lanes_d;
  logic [1:0]  lane_idx_q, lane_idx_d;
  logic [31:0] stage_data_q, stage_data_d;
  logic [3:0]  stage_k_q, stage_k_d;
  logic        dec_acc_q, dec_acc_d;
  logic        disp_acc_q, disp_acc_d;
  logic [31:0] rx_data_q, rx_data_d;
  logic [3:0]  rx_datak_q, rx_datak_d;
  logic [2:0]  rx_status_q, rx_status_d;
  logic        rx_valid_q, rx_valid_d;
  logic        align_q, align_d;

  logic [2:0]  n_dec;
  logic [2:0]  n_cur;
  logic [1:0]  lane_last;
  logic [31:0] byte_mask;
  logic [3:0]  k_mask;
  logic [31:0] merged_data;
  logic [3:0]  merged_k;
  logic        dec_any;
  logic        disp_any;
  logic        com_realign;

  always_comb begin
    case (DataBusWidth)
      6'd16:   n_dec = 3'd2;
      6'd32:   n_dec = 3'd4;
      default: n_dec = 3'd1;
    endcase

    // The lane count of a word is fixed by its first symbol.
    n_cur = (lane_idx_q == 2'd0) ? n_dec : lanes_q;

    case (n_cur)
      3'd2:    begin lane_last = 2'd1; byte_mask = 32'h0000_FFFF; k_mask = 4'b0011; end
      3'd4:    begin lane_last = 2'd3; byte_mask = 32'hFFFF_FFFF; k_mask = 4'b1111; end
      default: begin lane_last = 2'd0; byte_mask = 32'h0000_00FF; k_mask = 4'b0001; end
    endcase

    merged_data = stage_data_q | ({{(32-SYM_WIDTH){1'b0}}, Sym_Data} << {lane_idx_q, 3'b000});
    merged_k    = stage_k_q | ({3'b000, Sym_K} << lane_idx_q);
    dec_any     = dec_acc_q | Sym_DecErr;
    disp_any    = disp_acc_q | Sym_DispErr;

`ifdef RX_PACKER_COM_ALIGN_EN
    com_realign = Sym_K && (Sym_Data == 8'hBC) && (lane_idx_q != 2'd0);
`else
    com_realign = 1'b0;
`endif
  end

  always_comb begin
    lanes_d      = lanes_q;
    lane_idx_d   = lane_idx_q;
    stage_data_d = stage_data_q;
    stage_k_d    = stage_k_q;
    dec_acc_d    = dec_acc_q;
    disp_acc_d   = disp_acc_q;
    rx_data_d    = rx_data_q;
    rx_datak_d   = rx_datak_q;
    rx_status_d  = rx_status_q;
    rx_valid_d   = 1'b0;
    align_d      = 1'b0;

    if (!Sym_Lock) begin
      lane_idx_d   = 2'd0;
      stage_data_d = '0;
      stage_k_d    = '0;
      dec_acc_d    = 1'b0;
      disp_acc_d   = 1'b0;
    end else if (Sym_Valid) begin
      if (lane_idx_q == 2'd0)
        lanes_d = n_dec;

      if (com_realign) begin
        // Restart the word with the comma in lane 0; errors of the dropped symbols go too.
        stage_data_d = {{(32-SYM_WIDTH){1'b0}}, Sym_Data};
        stage_k_d    = 4'b0001;
        dec_acc_d    = Sym_DecErr;
        disp_acc_d   = Sym_DispErr;
        lane_idx_d   = 2'd1;
        align_d      = 1'b1;
      end else if (lane_idx_q == lane_last) begin
        rx_valid_d   = 1'b1;
        rx_data_d    = merged_data & byte_mask;
        rx_datak_d   = merged_k & k_mask;
        rx_status_d  = dec_any ? ST_DEC : (disp_any ? ST_DISP : ST_OK);
        stage_data_d = '0;
        stage_k_d    = '0;
        dec_acc_d    = 1'b0;
        disp_acc_d   = 1'b0;
        lane_idx_d   = 2'd0;
      end else begin
        stage_data_d = merged_data;
        stage_k_d    = merged_k;
        dec_acc_d    = dec_any;
        disp_acc_d   = disp_any;
        lane_idx_d   = 2'(lane_idx_q + 2'd1);
      end
    end
  end

  always_ff @(posedge Word_CLK) begin
    if (Reset) begin
      lanes_q      <= 3'd1;
      lane_idx_q   <= 2'd0;
      stage_data_q <= '0;
      stage_k_q    <= '0;
      dec_acc_q    <= 1'b0;
      disp_acc_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_datak_q   <= '0;
      rx_status_q  <= ST_OK;
      rx_valid_q   <= 1'b0;
      align_q      <= 1'b0;
    end else begin
      lanes_q      <= lanes_d;
      lane_idx_q   <= lane_idx_d;
      stage_data_q <= stage_data_d;
      stage_k_q    <= stage_k_d;
      dec_acc_q    <= dec_acc_d;
      disp_acc_q   <= disp_acc_d;
      rx_data_q    <= rx_data_d;
      rx_datak_q   <= rx_datak_d;
      rx_status_q  <= rx_status_d;
      rx_valid_q   <= rx_valid_d;
      align_q      <= align_d;
    end
  end

  assign Rx_Data     = rx_data_q;
  assign Rx_DataK    = rx_datak_q;
  assign Rx_Status   = rx_status_q;
  assign Rx_Valid    = rx_valid_q;
  assign Align_Event = align_q;

endmodule

// File: tb/tb_rx_symbol_packer.sv
// Directed bench for rx_symbol_packer; the COM case follows RX_PACKER_COM_ALIGN_EN.
module tb_rx_symbol_packer;

  logic        word_clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  sym_data = '0;
  logic        sym_k = 1'b0;
  logic        sym_valid = 1'b0;
  logic        sym_decerr = 1'b0;
  logic        sym_disperr = 1'b0;
  logic        sym_lock = 1'b1;
  logic [5:0]  data_bus_width = 6'd32;
  logic [31:0] rx_data;
  logic [3:0]  rx_datak;
  logic [2:0]  rx_status;
  logic        rx_valid;
  logic        align_event;

  int total = 0;
  int bad = 0;

  rx_symbol_packer #(.SYM_WIDTH(8)) dut (
    .Word_CLK     (word_clk),
    .Reset        (reset),
    .Sym_Data     (sym_data),
    .Sym_K        (sym_k),
    .Sym_Valid    (sym_valid),
    .Sym_DecErr   (sym_decerr),
    .Sym_DispErr  (sym_disperr),
    .Sym_Lock     (sym_lock),
    .DataBusWidth (data_bus_width),
    .Rx_Data      (rx_data),
    .Rx_DataK     (rx_datak),
    .Rx_Status    (rx_status),
    .Rx_Valid     (rx_valid),
    .Align_Event  (align_event)
  );

  always #5 word_clk = ~word_clk;

  // One symbol-clock cycle: inputs change on the falling edge, outputs are sampled 1 ns after the rising edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic k,
                     input logic de, input logic di, input logic lk);
    @(negedge word_clk);
    sym_valid   = v;
    sym_data    = d;
    sym_k       = k;
    sym_decerr  = de;
    sym_disperr = di;
    sym_lock    = lk;
    @(posedge word_clk);
    #1;
  endtask

  task automatic sym(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] k, input logic [2:0] s);
    chk({tag, ".valid"},  32'(rx_valid),  32'h1);
    chk({tag, ".data"},   rx_data,        d);
    chk({tag, ".k"},      32'(rx_datak),  32'(k));
    chk({tag, ".status"}, 32'(rx_status), 32'(s));
  endtask

  initial begin
    // Reset with a valid symbol presented: must be ignored.
    cyc(1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 8'h78, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst.valid",  32'(rx_valid),    32'h0);
    chk("rst.data",   rx_data,          32'h0);
    chk("rst.k",      32'(rx_datak),    32'h0);
    chk("rst.status", 32'(rx_status),   32'h0);
    chk("rst.align",  32'(align_event), 32'h0);
    reset = 1'b0;
    idle();
    chk("rst.post_valid", 32'(rx_valid), 32'h0);

    // 32-bit word, latency one cycle after the 4th symbol
    data_bus_width = 6'd32;
    sym(8'h11); sym(8'h22); sym(8'h33);
    chk("w32.early_valid", 32'(rx_valid), 32'h0);
    sym(8'h44);
    chk_word("w32", 32'h4433_2211, 4'b0000, 3'b000);
    idle();
    chk("w32.pulse_len", 32'(rx_valid), 32'h0);
    chk("w32.hold",      rx_data,       32'h4433_2211);

    // 16-bit K word, upper bytes zero
    data_bus_width = 6'd16;
    cyc(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("w16.early_valid", 32'(rx_valid),    32'h0);
    chk("w16.no_align",    32'(align_event), 32'h0);
    cyc(1'b1, 8'h1C, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_word("w16", 32'h0000_1CBC, 4'b0011, 3'b000);

    // Error accumulation: decode error dominates disparity error
    data_bus_width = 6'd32;
    sym(8'h01);
    cyc(1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1);
    sym(8'h03);
    cyc(1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_word("err.dec", 32'h0403_0201, 4'b0000, 3'b100);
    sym(8'h05); sym(8'h06); sym(8'h07); sym(8'h08);
    chk_word("err.clean", 32'h0807_0605, 4'b0000, 3'b000);
    sym(8'h09);
    cyc(1'b1, 8'h0A, 1'b0, 1'b0, 1'b1, 1'b1);
    sym(8'h0B); sym(8'h0C);
    chk_word("err.disp", 32'h0C0B_0A09, 4'b0000, 3'b111);
    idle();
    chk("err.hold_status", 32'(rx_status), 32'h7);

    // Lock loss drops the partial word and the symbol offered with it
    sym(8'hA1); sym(8'hA2);
    cyc(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lock.valid_low", 32'(rx_valid), 32'h0);
    sym(8'hB1); sym(8'hB2); sym(8'hB3);
    chk("lock.no_early", 32'(rx_valid), 32'h0);
    sym(8'hB4);
    chk_word("lock", 32'hB4B3_B2B1, 4'b0000, 3'b000);

    // 8-bit width with a gap between symbols
    data_bus_width = 6'd8;
    sym(8'h5A);
    chk_word("w8.a", 32'h0000_005A, 4'b0000, 3'b000);
    idle();
    chk("w8.gap_valid", 32'(rx_valid), 32'h0);
    chk("w8.gap_hold",  rx_data,       32'h0000_005A);
    sym(8'hA5);
    chk_word("w8.b", 32'h0000_00A5, 4'b0000, 3'b000);

    // Width change mid-word applies to the next word only
    data_bus_width = 6'd32;
    sym(8'hC1); sym(8'hC2);
    data_bus_width = 6'd8;
    sym(8'hC3);
    chk("wchg.no_early", 32'(rx_valid), 32'h0);
    sym(8'hC4);
    chk_word("wchg.old", 32'hC4C3_C2C1, 4'b0000, 3'b000);
    sym(8'hD1);
    chk_word("wchg.new", 32'h0000_00D1, 4'b0000, 3'b000);

    // Unsupported width behaves as 8
    data_bus_width = 6'd24;
    sym(8'h3C);
    chk_word("w24", 32'h0000_003C, 4'b0000, 3'b000);

    // Reset mid-word
    data_bus_width = 6'd32;
    sym(8'hE1); sym(8'hE2);
    reset = 1'b1;
    sym(8'hE3);
    reset = 1'b0;
    chk("mrst.valid", 32'(rx_valid), 32'h0);
    chk("mrst.data",  rx_data,       32'h0);
    sym(8'hF1); sym(8'hF2); sym(8'hF3);
    chk("mrst.no_early", 32'(rx_valid), 32'h0);
    sym(8'hF4);
    chk_word("mrst", 32'hF4F3_F2F1, 4'b0000, 3'b000);

    // COM symbol at lane 2
    data_bus_width = 6'd32;
    sym(8'hAA);
    cyc(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef RX_PACKER_COM_ALIGN_EN
    chk("com.align",  32'(align_event), 32'h1);
    chk("com.valid0", 32'(rx_valid),    32'h0);
    sym(8'h01);
    chk("com.align_len", 32'(align_event), 32'h0);
    sym(8'h02);
    sym(8'h03);
    chk_word("com", 32'h0302_01BC, 4'b0001, 3'b000);
`else
    chk("com.no_align", 32'(align_event), 32'h0);
    sym(8'h01);
    chk_word("com", 32'h01BC_BBAA, 4'b0100, 3'b111);
    chk("com.no_align2", 32'(align_event), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rx_symbol_packer.md
RX_SYMBOL_PACKER -- requirements
Module: rx_symbol_packer

Interface
REQ-001 SHALL have parameter SYM_WIDTH, default 8, meaning decoded symbol width in bits (fixed at 8; other values unsupported).
REQ-002 SHALL have port Word_CLK  input  1  symbol-rate clock; all logic on its rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Sym_Data  input  8  decoded symbol from the 8b/10b decoder.
REQ-005 SHALL have port Sym_K  input  1  symbol is a control (K) character.
REQ-006 SHALL have port Sym_Valid  input  1  symbol qualifier; symbol accepted on each cycle it is high.
REQ-007 SHALL have port Sym_DecErr  input  1  8b/10b code violation on this symbol.
REQ-008 SHALL have port Sym_DispErr  input  1  running-disparity error on this symbol.
REQ-009 SHALL have port Sym_Lock  input  1  symbol lock from the comma detector; low means the stream is not aligned.
REQ-010 SHALL have port DataBusWidth  input  6  MAC data width in bits: 8, 16 or 32.
REQ-011 SHALL have port Rx_Data  output  32  packed word; first-received symbol in [7:0].
REQ-012 SHALL have port Rx_DataK  output  4  per-byte K flags aligned with Rx_Data bytes.
REQ-013 SHALL have port Rx_Status  output  3  000 OK, 100 decode error, 111 disparity error.
REQ-014 SHALL have port Rx_Valid  output  1  one-cycle pulse qualifying Rx_Data/Rx_DataK/Rx_Status.
REQ-015 SHALL have port Align_Event  output  1  one-cycle pulse when a comma realignment discards a partial word.

Function
REQ-016 SHALL decode the lane count N as 1 for DataBusWidth=8, 2 for 16 and 4 for 32; any other value SHALL be treated as 8.
REQ-017 SHALL latch N only when the lane index is 0 and a symbol is accepted; a DataBusWidth change mid-word SHALL take effect at the next word.
REQ-018 SHALL keep a lane index 0..N-1: it increments on each accepted symbol and wraps to 0 after lane N-1.
REQ-019 SHALL store the symbol accepted at lane i into byte i of the staging word (bits 8i+7:8i) and its Sym_K into K bit i.
REQ-020 SHALL assert Rx_Valid exactly one cycle after the lane N-1 symbol is accepted (latency 1), with Rx_Data/Rx_DataK updated in that same cycle.
REQ-021 SHALL drive unused upper bytes of Rx_Data and unused Rx_DataK bits to 0 when N is less than 4.
REQ-022 SHALL hold Rx_Data, Rx_DataK and Rx_Status unchanged between Rx_Valid pulses.
REQ-023 SHALL OR-accumulate Sym_DecErr and Sym_DispErr across the symbols of a word; Rx_Status SHALL be 100 if any decode error, else 111 if any disparity error, else 000.
REQ-024 SHALL clear the error accumulators when a word completes, so a new word can start at lane 0 in the following cycle.
REQ-025 SHALL discard a partial word, force the lane index to 0 and suppress Rx_Valid when Sym_Lock is low.
REQ-026 SHALL give priority to Sym_Lock low over a simultaneous Sym_Valid, dropping that symbol.
REQ-027 SHALL treat cycles with Sym_Valid low as gaps: the lane index and accumulators hold their values.

Reset
REQ-028 SHALL, while Reset is high, drive Rx_Data=0, Rx_DataK=0, Rx_Status=000, Rx_Valid=0 and Align_Event=0, clear the lane index and accumulators, and set N=1.
REQ-029 SHALL, when Reset is asserted mid-word, discard the partial word with no Rx_Valid pulse; symbols presented in the reset cycle are ignored.

Configuration
REQ-030 SHALL support macro RX_PACKER_COM_ALIGN_EN; when it is defined, an accepted COM symbol (Sym_K=1, Sym_Data=8'hBC) at lane index not equal to 0 SHALL discard the partial word and its errors, be placed in lane 0 with the index set to 1, and pulse Align_Event in the next cycle.
REQ-031 SHALL, when RX_PACKER_COM_ALIGN_EN is undefined, give COM no special handling and tie Align_Event to 0.

Verification
REQ-032 SHALL cover: DataBusWidth=32, symbols 11,22,33,44 with Sym_K=0 -> one cycle later Rx_Valid=1, Rx_Data=32'h44332211, Rx_DataK=0000, Rx_Status=000.
REQ-033 SHALL cover: DataBusWidth=16, symbols BC(K),1C(K) -> Rx_Data=32'h00001CBC, Rx_DataK=0011.
REQ-034 SHALL cover: DataBusWidth=32, Sym_DispErr on symbol 1 and Sym_DecErr on symbol 3 -> Rx_Status=100; the next clean word -> Rx_Status=000.
REQ-035 SHALL cover: DataBusWidth=32, two symbols then Sym_Lock=0 for 1 cycle, then four symbols -> exactly one Rx_Valid, containing only the last four symbols.
REQ-036 SHALL cover: with the macro defined, DataBusWidth=32, symbols AA,BB,BC(K),01,02,03 -> Align_Event pulse, then Rx_Data=32'h030201BC, Rx_DataK=0001.
REQ-037 SHALL cover: DataBusWidth=8 with Sym_Valid toggling 1,0,1 on symbols 5A,A5 -> two Rx_Valid pulses carrying 32'h0000005A then 32'h000000A5.
